red_pitaya_pid_seq: RTL and testbench



---
 rtl/red_pitaya_pid_seq.sv | 198 +++++++++++++++++++
 tb/tb_red_pitaya_pid_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pid_seq.sv
// Setpoint ramp / integrator-reset sequencer for one PID block.
// On start it holds the integrator in reset, slews the setpoint toward a
// latched target in bounded steps at a programmable rate, waits a settle
// time and then pulses done. Abort returns to IDLE, keeps the setpoint and
// re-asserts the integrator reset.
//
// Handshake: start_i is a level and is sampled every cycle. It is accepted
// only in IDLE with abort_i low. done_o is a single-cycle pulse that
// coincides with busy_o falling. abort_i overrides everything in every state.
module red_pitaya_pid_seq #(
  parameter int IRST_LEN = 16,
  parameter int IW       = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [13:0]   target_i,
  input  logic [13:0]   step_i,
  input  logic [IW-1:0] interval_i,
  input  logic [IW-1:0] settle_i,
  output logic [13:0]   sp_o,
  output logic          irst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [2:0]    dbg_state_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_IRST   = 3'd1;
  localparam logic [2:0] ST_RAMP   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // The integrator-reset counter only needs to reach IRST_LEN-1.
  localparam int         RW        = (IRST_LEN > 1) ? $clog2(IRST_LEN) : 1;
  localparam logic [RW-1:0] IRST_LAST = RW'(IRST_LEN - 1);

  logic [2:0]    state_q,    state_d;
  logic [13:0]   sp_q,       sp_d;
  logic          irst_q,     irst_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic [13:0]   tgt_q,      tgt_d;
  logic [13:0]   step_q,     step_d;
  logic [IW-1:0] intv_q,     intv_d;
  logic [IW-1:0] settle_q,   settle_d;
  logic [IW-1:0] cnt_q,      cnt_d;
  logic [RW-1:0] irst_cnt_q, irst_cnt_d;

  logic signed [14:0] diff;
  logic [14:0]        abs_diff;
  logic [14:0]        sp_ext;
  logic [14:0]        step_ext;
  logic [13:0]        sp_upd;
  logic               ramp_end;

  // One ramp update: 15-bit difference so target - sp never overflows;
  // a non-final step always stays inside the 14-bit range because the
  // remaining distance exceeds the step.
  always_comb begin
    sp_ext   = {sp_q[13], sp_q};
    step_ext = {1'b0, step_q};
    diff     = $signed({tgt_q[13], tgt_q}) - $signed(sp_ext);
    abs_diff = diff[14] ? 15'(-diff) : 15'(diff);
    if ((step_q == 14'd0) || (abs_diff <= step_ext)) begin
      sp_upd = tgt_q;
    end else if (diff[14]) begin
      sp_upd = 14'(sp_ext - step_ext);
    end else begin
      sp_upd = 14'(sp_ext + step_ext);
    end
  end

  // Next-state and output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    irst_d     = irst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tgt_d      = tgt_q;
    step_d     = step_q;
    intv_d     = intv_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    irst_cnt_d = irst_cnt_q;
    ramp_end   = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      irst_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            tgt_d      = target_i;
            step_d     = step_i;
            intv_d     = interval_i;
            settle_d   = settle_i;
            irst_cnt_d = '0;
            state_d    = ST_IRST;
            irst_d     = 1'b1;
            busy_d     = 1'b1;
          end
        end
        ST_IRST: begin
          if (irst_cnt_q == IRST_LAST) begin
            state_d = ST_RAMP;
            irst_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            irst_cnt_d = irst_cnt_q + RW'(1);
          end
        end
        ST_RAMP: begin
          if (sp_q == tgt_q) begin
            ramp_end = 1'b1;
          end else if (cnt_q == intv_q) begin
            sp_d  = sp_upd;
            cnt_d = '0;
            if (sp_upd == tgt_q) begin
              ramp_end = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == (settle_q - IW'(1))) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          irst_d  = 1'b1;
          busy_d  = 1'b0;
        end
      endcase

      // Target reached: skip SETTLE entirely when no settle time is set.
      if (ramp_end) begin
        cnt_d = '0;
        if (settle_q == '0) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      sp_q       <= '0;
      irst_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tgt_q      <= '0;
      step_q     <= '0;
      intv_q     <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      irst_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      irst_q     <= irst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      intv_q     <= intv_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      irst_cnt_q <= irst_cnt_d;
    end
  end

  assign sp_o        = sp_q;
  assign irst_o      = irst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_red_pitaya_pid_seq.sv
// Directed bench for the setpoint ramp sequencer (IRST_LEN=4, IW=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_red_pitaya_pid_seq;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [13:0] target_i = '0;
  logic [13:0] step_i = '0;
  logic [15:0] interval_i = '0;
  logic [15:0] settle_i = '0;
  logic [13:0] sp_o;
  logic        irst_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int failures = 0;
  logic [13:0] exp_q[$];

  red_pitaya_pid_seq #(.IRST_LEN(4), .IW(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
    .target_i(target_i), .step_i(step_i), .interval_i(interval_i),
    .settle_i(settle_i), .sp_o(sp_o), .irst_o(irst_o), .busy_o(busy_o),
    .done_o(done_o), .dbg_state_o(dbg_state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    wait_n(2);
    rstn_i = 1'b1;
  endtask

  // Presents a start for one rising edge; returns on the falling edge after it.
  task automatic start_seq(input logic [13:0] tgt, input logic [13:0] stp,
                           input logic [15:0] intv, input logic [15:0] stl);
    target_i = tgt; step_i = stp; interval_i = intv; settle_i = stl;
    start_i = 1'b1;
    wait_n(1);
    start_i = 1'b0;
  endtask

  // Jump to a value with no ramp and no settle, bounded wait for done.
  task automatic run_to(input logic [13:0] tgt);
    int n;
    start_seq(tgt, 14'd0, 16'd0, 16'd0);
    n = 0;
    while (!done_o && n < 40) begin
      wait_n(1);
      n++;
    end
    chk("run_to_done", 14'(done_o), 14'd1);
    chk("run_to_sp", sp_o, tgt);
    wait_n(1);
  endtask

  initial begin
    int dcnt;

    // reset state
    do_reset();
    chk("rst_sp", sp_o, 14'd0);
    chk("rst_irst", 14'(irst_o), 14'd1);
    chk("rst_busy", 14'(busy_o), 14'd0);
    chk("rst_done", 14'(done_o), 14'd0);

    // scenario 1: ramp 0 -> 100, step 30, interval 3, settle 5; late start ignored
    exp_q.push_back(14'd30);
    exp_q.push_back(14'd60);
    exp_q.push_back(14'd90);
    exp_q.push_back(14'd100);
    start_seq(14'd100, 14'd30, 16'd3, 16'd5);
    chk("s1_irst_c1", 14'(irst_o), 14'd1);
    chk("s1_busy_c1", 14'(busy_o), 14'd1);
    wait_n(3);
    chk("s1_irst_c4", 14'(irst_o), 14'd1);
    wait_n(1);
    chk("s1_irst_off", 14'(irst_o), 14'd0);
    chk("s1_busy_ramp", 14'(busy_o), 14'd1);
    wait_n(3);
    chk("s1_sp_pre", sp_o, 14'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        target_i = 14'(-50);
        step_i = 14'd1;
        start_i = 1'b1;
        wait_n(1);
        start_i = 1'b0;
        wait_n(3);
      end else begin
        wait_n(i == 0 ? 1 : 4);
      end
      chk("s1_sp_step", sp_o, exp_q.pop_front());
    end
    chk("s1_busy_settle", 14'(busy_o), 14'd1);
    wait_n(4);
    chk("s1_done_early", 14'(done_o), 14'd0);
    wait_n(1);
    chk("s1_done", 14'(done_o), 14'd1);
    chk("s1_busy_done", 14'(busy_o), 14'd0);
    chk("s1_irst_done", 14'(irst_o), 14'd0);
    chk("s1_sp_final", sp_o, 14'd100);
    wait_n(1);
    chk("s1_done_once", 14'(done_o), 14'd0);

    // scenario 2: full-scale jump, step 0 and step 16383
    run_to(14'd8191);
    start_seq(14'(-8192), 14'd0, 16'd2, 16'd1);
    wait_n(6);
    chk("s2_sp_hold", sp_o, 14'd8191);
    wait_n(1);
    chk("s2_sp_jump", sp_o, 14'(-8192));
    chk("s2_done_settle", 14'(done_o), 14'd0);
    wait_n(1);
    chk("s2_done", 14'(done_o), 14'd1);
    wait_n(1);
    run_to(14'd8191);
    start_seq(14'(-8192), 14'd16383, 16'd0, 16'd0);
    wait_n(5);
    chk("s2b_sp_jump", sp_o, 14'(-8192));
    chk("s2b_done", 14'(done_o), 14'd1);
    wait_n(1);

    // scenario 3: target equals setpoint, settle 0
    start_seq(14'(-8192), 14'd5, 16'd3, 16'd0);
    wait_n(4);
    chk("s3_irst_off", 14'(irst_o), 14'd0);
    chk("s3_busy", 14'(busy_o), 14'd1);
    wait_n(1);
    chk("s3_done", 14'(done_o), 14'd1);
    chk("s3_busy_off", 14'(busy_o), 14'd0);
    chk("s3_sp", sp_o, 14'(-8192));
    wait_n(1);

    // scenario 4: abort once the ramp reaches 60
    do_reset();
    start_seq(14'd100, 14'd30, 16'd3, 16'd5);
    wait_n(12);
    chk("s4_sp60", sp_o, 14'd60);
    abort_i = 1'b1;
    wait_n(1);
    abort_i = 1'b0;
    chk("s4_irst", 14'(irst_o), 14'd1);
    chk("s4_busy", 14'(busy_o), 14'd0);
    chk("s4_sp_hold", sp_o, 14'd60);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      wait_n(1);
      if (done_o) dcnt++;
    end
    chk("s4_no_done", 14'(dcnt), 14'd0);
    chk("s4_sp_after", sp_o, 14'd60);

    // scenario 5: start and abort together in IDLE
    target_i = 14'd500;
    start_i = 1'b1;
    abort_i = 1'b1;
    wait_n(1);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("s5_busy", 14'(busy_o), 14'd0);
    chk("s5_irst", 14'(irst_o), 14'd1);
    wait_n(2);
    chk("s5_busy_later", 14'(busy_o), 14'd0);
    chk("s5_sp", sp_o, 14'd60);

    // scenario 6: reset pulse during SETTLE, then a normal negative ramp
    start_seq(14'd100, 14'd50, 16'd0, 16'd10);
    wait_n(5);
    chk("s6_sp100", sp_o, 14'd100);
    chk("s6_busy", 14'(busy_o), 14'd1);
    wait_n(2);
    rstn_i = 1'b0;
    wait_n(1);
    rstn_i = 1'b1;
    chk("s6_rst_sp", sp_o, 14'd0);
    chk("s6_rst_irst", 14'(irst_o), 14'd1);
    chk("s6_rst_busy", 14'(busy_o), 14'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      wait_n(1);
      if (done_o) dcnt++;
    end
    chk("s6_no_done", 14'(dcnt), 14'd0);
    start_seq(14'(-20), 14'd7, 16'd1, 16'd2);
    wait_n(6);
    chk("s6_sp_m7", sp_o, 14'(-7));
    wait_n(2);
    chk("s6_sp_m14", sp_o, 14'(-14));
    wait_n(2);
    chk("s6_sp_m20", sp_o, 14'(-20));
    chk("s6_done_early", 14'(done_o), 14'd0);
    wait_n(1);
    chk("s6_busy_settle", 14'(busy_o), 14'd1);
    wait_n(1);
    chk("s6_done", 14'(done_o), 14'd1);
    chk("s6_busy_off", 14'(busy_o), 14'd0);
    wait_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
